// File: rtl/clock_time_display.sv
// Time-of-day keeper (BCD HH:MM:SS) with set buttons, driving a 4-digit muxed 7-segment display.
// Optional 12-hour mode with pm indicator on dp at digit 0: define TWELVE_HOUR_EN.
module clock_time_display #(
  parameter int SYNC_STAGES    = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       cmosClock,
  input  logic       resetN,
  input  logic       secondClock,
  input  logic       displayClock,
  input  logic       incHour,
  input  logic       incMinute,
  output logic [3:0] anodes,
  output logic [6:0] segments,
  output logic       dp,
  output logic [7:0] hoursBcd,
  output logic [7:0] minutesBcd
);

`ifdef TWELVE_HOUR_EN
  localparam logic [3:0] RST_HR_T = 4'd1;
  localparam logic [3:0] RST_HR_O = 4'd2;
`else
  localparam logic [3:0] RST_HR_T = 4'd0;
  localparam logic [3:0] RST_HR_O = 4'd0;
`endif
  localparam logic [6:0] SEG_ZERO = 7'b0111111;
  localparam logic [6:0] RST_SEG  = SEG_ACTIVE_LOW ? ~SEG_ZERO : SEG_ZERO;
  localparam logic       RST_DP   = SEG_ACTIVE_LOW;

  // Bit order in every sync stage: {incMinute, incHour, displayClock, secondClock}
  logic [3:0] asyncIn;
  logic [3:0] syncStage [SYNC_STAGES];
  logic [3:0] edgeReg;
  logic [3:0] pulses;
  logic       secTick, scanTick, hourEdge, minEdge;

  assign asyncIn  = {incMinute, incHour, displayClock, secondClock};
  assign pulses   = syncStage[SYNC_STAGES-1] & ~edgeReg;
  assign secTick  = pulses[0];
  assign scanTick = pulses[1];
  assign hourEdge = pulses[2];
  assign minEdge  = pulses[3];

  logic [3:0] secT, secO, minT, minO, hrT, hrO;
  logic [3:0] nSecT, nSecO, nMinT, nMinO, nHrT, nHrO;
  logic [1:0] idx;
  logic       hourStep;
`ifdef TWELVE_HOUR_EN
  logic       pm, nPm;
`endif

  function automatic logic [7:0] next60(input logic [3:0] t, input logic [3:0] o);
    if (o == 4'd9) return (t == 4'd5) ? 8'h00 : {t + 4'd1, 4'd0};
    return {t, o + 4'd1};
  endfunction

  function automatic logic [7:0] nextHour(input logic [3:0] t, input logic [3:0] o);
`ifdef TWELVE_HOUR_EN
    if (t == 4'd1 && o == 4'd2) return 8'h01;
`else
    if (t == 4'd2 && o == 4'd3) return 8'h00;
`endif
    if (o == 4'd9) return {t + 4'd1, 4'd0};
    return {t, o + 4'd1};
  endfunction

  function automatic logic [6:0] segDecode(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0111111;
      4'd1: return 7'b0000110;
      4'd2: return 7'b1011011;
      4'd3: return 7'b1001111;
      4'd4: return 7'b1100110;
      4'd5: return 7'b1101101;
      4'd6: return 7'b1111101;
      4'd7: return 7'b0000111;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  // Button edges pre-empt a coincident second tick; carries ripple within one cycle.
  always_comb begin
    nSecT = secT; nSecO = secO;
    nMinT = minT; nMinO = minO;
    nHrT  = hrT;  nHrO  = hrO;
    hourStep = 1'b0;
    if (hourEdge || minEdge) begin
      if (minEdge) begin
        {nMinT, nMinO} = next60(minT, minO);
        nSecT = 4'd0;
        nSecO = 4'd0;
      end
      hourStep = hourEdge;
    end else if (secTick) begin
      {nSecT, nSecO} = next60(secT, secO);
      if (secT == 4'd5 && secO == 4'd9) begin
        {nMinT, nMinO} = next60(minT, minO);
        hourStep = (minT == 4'd5 && minO == 4'd9);
      end
    end
    if (hourStep) {nHrT, nHrO} = nextHour(hrT, hrO);
`ifdef TWELVE_HOUR_EN
    nPm = pm ^ (hourStep && hrT == 4'd1 && hrO == 4'd1);
`endif
  end

  logic [3:0] digit;
  logic       blank, dpOn;

  always_comb begin
    case (idx)
      2'd0:    digit = minO;
      2'd1:    digit = minT;
      2'd2:    digit = hrO;
      default: digit = hrT;
    endcase
    blank = (idx == 2'd3) && (hrT == 4'd0);
    dpOn  = (idx == 2'd2) && !secO[0];
`ifdef TWELVE_HOUR_EN
    dpOn  = dpOn || ((idx == 2'd0) && pm);
`endif
  end

  always_ff @(posedge cmosClock) begin
    if (!resetN) begin
      for (int i = 0; i < SYNC_STAGES; i++) syncStage[i] <= 4'd0;
      edgeReg  <= 4'd0;
      secT <= 4'd0; secO <= 4'd0;
      minT <= 4'd0; minO <= 4'd0;
      hrT  <= RST_HR_T; hrO <= RST_HR_O;
      idx      <= 2'd0;
      anodes   <= 4'b1110;
      segments <= RST_SEG;
      dp       <= RST_DP;
`ifdef TWELVE_HOUR_EN
      pm       <= 1'b0;
`endif
    end else begin
      syncStage[0] <= asyncIn;
      for (int i = 1; i < SYNC_STAGES; i++) syncStage[i] <= syncStage[i-1];
      edgeReg <= syncStage[SYNC_STAGES-1];
      secT <= nSecT; secO <= nSecO;
      minT <= nMinT; minO <= nMinO;
      hrT  <= nHrT;  hrO  <= nHrO;
`ifdef TWELVE_HOUR_EN
      pm   <= nPm;
`endif
      if (scanTick) idx <= idx + 2'd1;
      anodes   <= ~(4'b0001 << idx);
      segments <= SEG_ACTIVE_LOW ? ~(blank ? 7'b0000000 : segDecode(digit))
                                 :  (blank ? 7'b0000000 : segDecode(digit));
      dp       <= SEG_ACTIVE_LOW ? ~dpOn : dpOn;
    end
  end

  assign hoursBcd   = {hrT, hrO};
  assign minutesBcd = {minT, minO};

endmodule

// File: tb/tb_clock_time_display.sv
// Directed bench for clock_time_display: reset, rollover, button priority, digit scan.
module tb_clock_time_display;

  logic       cmosClock = 1'b0;
  logic       resetN = 1'b0;
  logic       secondClock = 1'b0, displayClock = 1'b0, incHour = 1'b0, incMinute = 1'b0;
  logic [3:0] anodes;
  logic [6:0] segments;
  logic       dp;
  logic [7:0] hoursBcd, minutesBcd;

  int nAsserts = 0;
  int nFail = 0;

  clock_time_display #(.SYNC_STAGES(2), .SEG_ACTIVE_LOW(1'b1)) dut (
    .cmosClock(cmosClock), .resetN(resetN),
    .secondClock(secondClock), .displayClock(displayClock),
    .incHour(incHour), .incMinute(incMinute),
    .anodes(anodes), .segments(segments), .dp(dp),
    .hoursBcd(hoursBcd), .minutesBcd(minutesBcd)
  );

  always #5 cmosClock = ~cmosClock;

  task automatic cyc(input int n);
    repeat (n) @(posedge cmosClock);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // which: 0 secondClock, 1 displayClock, 2 incHour, 3 incMinute
  task automatic pulseSig(input int which, input int hold);
    case (which)
      0: secondClock = 1'b1;
      1: displayClock = 1'b1;
      2: incHour = 1'b1;
      default: incMinute = 1'b1;
    endcase
    cyc(hold);
    secondClock = 1'b0; displayClock = 1'b0; incHour = 1'b0; incMinute = 1'b0;
    cyc(5);
  endtask

  task automatic repeatPulse(input int which, input int n);
    for (int k = 0; k < n; k++) pulseSig(which, 5);
  endtask

  // Expected registered display outputs for 07:45:xx with even seconds
  function automatic logic [6:0] expSeg0745(input int i);
    case (i)
      0: return 7'b0010010;
      1: return 7'b0011001;
      2: return 7'b1111000;
      default: return 7'b1111111;
    endcase
  endfunction

  initial begin
    logic [3:0] expAn;
    logic       bad;
    int         expIdx;

    cyc(4);
`ifdef TWELVE_HOUR_EN
    check("reset_hours", hoursBcd, 8'h12);
`else
    check("reset_hours", hoursBcd, 8'h00);
`endif
    check("reset_anodes", {4'h0, anodes}, 8'h0E);
    check("reset_segments", {1'b0, segments}, 8'h40);
    check("reset_dp", {7'h0, dp}, 8'h01);
    check("reset_minutes", minutesBcd, 8'h00);
    resetN = 1'b1;
    cyc(3);

`ifndef TWELVE_HOUR_EN
    // Load 23:59:58 and roll over
    repeatPulse(2, 23);
    check("load_hours23", hoursBcd, 8'h23);
    repeatPulse(3, 59);
    check("load_min59", minutesBcd, 8'h59);
    repeatPulse(0, 58);
    pulseSig(0, 5);
    check("t59_hours", hoursBcd, 8'h23);
    check("t59_minutes", minutesBcd, 8'h59);
    bad = 1'b0;
    secondClock = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      if (!({hoursBcd, minutesBcd} == 16'h2359 || {hoursBcd, minutesBcd} == 16'h0000)) bad = 1'b1;
    end
    secondClock = 1'b0;
    cyc(5);
    check("rollover_atomic", {7'h0, bad}, 8'h00);
    check("rollover_hours", hoursBcd, 8'h00);
    check("rollover_minutes", minutesBcd, 8'h00);
    repeatPulse(1, 2);
    check("idx2_anodes", {4'h0, anodes}, 8'h0B);
    check("rollover_secO_even_dp", {7'h0, dp}, 8'h00);

    // Held incMinute at 10:59:30 gives exactly one increment and clears seconds
    repeatPulse(2, 10);
    repeatPulse(3, 59);
    repeatPulse(0, 30);
    check("pre_hold_min", minutesBcd, 8'h59);
    pulseSig(3, 1000);
    check("hold_minutes", minutesBcd, 8'h00);
    check("hold_hours", hoursBcd, 8'h10);
    repeatPulse(0, 59);
    check("hold_sec_cleared_a", minutesBcd, 8'h00);
    pulseSig(0, 5);
    check("hold_sec_cleared_b", minutesBcd, 8'h01);

    // 05:20:59, second tick coincident with hour edge is dropped
    repeatPulse(2, 19);
    repeatPulse(3, 19);
    repeatPulse(0, 59);
    check("pre_prio_hours", hoursBcd, 8'h05);
    check("pre_prio_minutes", minutesBcd, 8'h20);
    secondClock = 1'b1; incHour = 1'b1;
    cyc(5);
    secondClock = 1'b0; incHour = 1'b0;
    cyc(5);
    check("prio_hours", hoursBcd, 8'h06);
    check("prio_minutes", minutesBcd, 8'h20);
    check("prio_secO_odd_dp", {7'h0, dp}, 8'h01);
    pulseSig(0, 5);
    check("prio_sec59_carry", minutesBcd, 8'h21);

    // Scan sequence at 07:45:00
    pulseSig(2, 5);
    repeatPulse(3, 24);
    check("scan_hours", hoursBcd, 8'h07);
    check("scan_minutes", minutesBcd, 8'h45);
    repeatPulse(1, 2);
    check("scan0_anodes", {4'h0, anodes}, 8'h0E);
    check("scan0_segments", {1'b0, segments}, {1'b0, expSeg0745(0)});
    check("scan0_dp", {7'h0, dp}, 8'h01);
    for (int s = 1; s <= 8; s++) begin
      pulseSig(1, 5);
      expIdx = s % 4;
      expAn = ~(4'b0001 << expIdx);
      check($sformatf("scan%0d_anodes", s), {4'h0, anodes}, {4'h0, expAn});
      check($sformatf("scan%0d_segments", s), {1'b0, segments}, {1'b0, expSeg0745(expIdx)});
      check($sformatf("scan%0d_dp", s), {7'h0, dp}, (expIdx == 2) ? 8'h00 : 8'h01);
    end

    // Reset mid-operation
    resetN = 1'b0;
    cyc(2);
    check("midrst_hours", hoursBcd, 8'h00);
    check("midrst_minutes", minutesBcd, 8'h00);
    check("midrst_anodes", {4'h0, anodes}, 8'h0E);
    resetN = 1'b1;
    cyc(3);
`else
    // 12-hour mode: 11:59:59 -> 12:00:00 pm, then 12:59:59 -> 01:00:00
    repeatPulse(2, 11);
    check("h12_load_hours", hoursBcd, 8'h11);
    repeatPulse(3, 59);
    repeatPulse(0, 59);
    pulseSig(0, 5);
    check("h12_noon_hours", hoursBcd, 8'h12);
    check("h12_noon_minutes", minutesBcd, 8'h00);
    check("h12_pm_dp_idx0", {7'h0, dp}, 8'h00);
    repeatPulse(3, 59);
    repeatPulse(0, 59);
    pulseSig(0, 5);
    check("h12_one_hours", hoursBcd, 8'h01);
    check("h12_one_minutes", minutesBcd, 8'h00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
